bpm_beat_gen: RTL

//  Downstream consumer of the UART BPM receiver. Takes each received 32-bit BPM word and range-checks it.

---
 rtl/bpm_beat_gen.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bpm_beat_gen.sv
// bpm_beat_gen: turns received BPM words into a metronome beat stream.
//   Range-checks each strobed tempo, converts it to a beat period in clock
//   cycles ((CLK_HZ*60)/bpm) with a 32-iteration restoring divider, then
//   emits one-cycle beats at that period with bar position and downbeat accent.
// Ports:
//   i_clk, i_reset_n      clock, synchronous active-low reset
//   i_bpm_valid, i_bpm    tempo strobe and 32-bit tempo word
//   i_enable              1 = beats run, 0 = muted with phase cleared
//   o_beat, o_accent      beat pulse, downbeat accent
//   o_beat_idx            index of the next beat in the bar
//   o_period              active beat period in clock cycles
//   o_busy                divider running
//   o_bpm_err             out-of-range tempo dropped (one-cycle pulse)
module bpm_beat_gen #(
  parameter int CLK_HZ        = 10_000_000,
  parameter int MIN_BPM       = 20,
  parameter int MAX_BPM       = 300,
  parameter int BEATS_PER_BAR = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_bpm_valid,
  input  logic [31:0] i_bpm,
  input  logic        i_enable,
  output logic        o_beat,
  output logic        o_accent,
  output logic [3:0]  o_beat_idx,
  output logic [31:0] o_period,
  output logic        o_busy,
  output logic        o_bpm_err
);

  localparam logic [31:0] DIVIDEND = 32'(CLK_HZ * 60);
  localparam logic [31:0] MIN_W    = 32'(MIN_BPM);
  localparam logic [31:0] MAX_W    = 32'(MAX_BPM);
  localparam logic [3:0]  LAST_IDX = 4'(BEATS_PER_BAR - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_RUN} state_t;

  state_t      state, state_nxt;
  logic        bpm_ok;
  logic        div_load, div_step, div_done, busy_nxt;

  logic [31:0] bpm_q;
  logic [31:0] rem, quo;
  logic [4:0]  it_cnt;
  logic [32:0] rem_sh, diff;
  logic        sub_ok;
  logic [31:0] rem_n, quo_n;

  logic [31:0] cnt;
  logic        live;   // phase is running; cleared so the next enabled cycle fires a downbeat
  logic        wrap;

  assign bpm_ok = i_bpm_valid && (i_bpm >= MIN_W) && (i_bpm <= MAX_W);

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // FSM: next state; a valid strobe always (re)starts the division
  always_comb begin
    state_nxt = state;
    if (bpm_ok)
      state_nxt = S_DIVIDE;
    else if (state == S_DIVIDE && it_cnt == 5'd31)
      state_nxt = S_RUN;
  end

  // FSM: control outputs
  always_comb begin
    div_load = bpm_ok;
    div_step = (state == S_DIVIDE) && !bpm_ok;
    div_done = div_step && (it_cnt == 5'd31);
    busy_nxt = (state_nxt == S_DIVIDE);
  end

  // Restoring divider: shift the next dividend bit into the remainder,
  // subtract when it fits; quotient bits shift in where dividend bits left.
  assign rem_sh = {rem, quo[31]};
  assign diff   = rem_sh - {1'b0, bpm_q};
  assign sub_ok = (rem_sh >= {1'b0, bpm_q});
  assign rem_n  = sub_ok ? diff[31:0] : rem_sh[31:0];
  assign quo_n  = {quo[30:0], sub_ok};

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      bpm_q     <= '0;
      rem       <= '0;
      quo       <= '0;
      it_cnt    <= '0;
      o_period  <= '0;
      o_busy    <= 1'b0;
      o_bpm_err <= 1'b0;
    end else begin
      o_bpm_err <= i_bpm_valid && !bpm_ok;
      o_busy    <= busy_nxt;
      if (div_load) begin
        bpm_q  <= i_bpm;
        rem    <= '0;
        quo    <= DIVIDEND;
        it_cnt <= '0;
      end else if (div_step) begin
        rem    <= rem_n;
        quo    <= quo_n;
        it_cnt <= it_cnt + 5'd1;
        if (div_done) o_period <= quo_n;
      end
    end
  end

  // Beat timing runs from o_period alone, so the old period keeps beating
  // during a re-divide. o_period is nonzero only once a division finished.
  // The >= compare makes a shortened period fire immediately.
  assign wrap = (cnt >= o_period - 32'd1);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt        <= '0;
      live       <= 1'b0;
      o_beat     <= 1'b0;
      o_accent   <= 1'b0;
      o_beat_idx <= '0;
    end else begin
      o_beat   <= 1'b0;
      o_accent <= 1'b0;
      if (!i_enable) begin
        cnt        <= '0;
        live       <= 1'b0;
        o_beat_idx <= '0;
      end else if (o_period != '0) begin
        if (!live || wrap) begin
          o_beat     <= 1'b1;
          o_accent   <= (o_beat_idx == 4'd0);
          o_beat_idx <= (o_beat_idx == LAST_IDX) ? 4'd0 : o_beat_idx + 4'd1;
          cnt        <= '0;
          live       <= 1'b1;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end
    end
  end

endmodule
